// File: rtl/jk_excite_seq.sv
// rtl/jk_excite_seq.sv - JK bank excitation sequencer with readback and retry (option: JK_TOGGLE_EN)
module jk_excite_seq #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2,
  localparam int AW       = $clog2(MAX_RETRY + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             ok,
  output logic [WIDTH-1:0] err_mask,
  output logic [AW-1:0]    attempts
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [AW-1:0]    retry_q, retry_d;
  logic [WIDTH-1:0] j_d, k_d, err_d;
  logic             done_d, ok_d;
  logic [AW-1:0]    att_d;
  logic [WIDTH-1:0] ex_tgt, ex_diff, ex_j, ex_k;

  assign tgt_ready = (state_q == S_IDLE);

  // Excitation: in IDLE the incoming word is the target, afterwards the latched one
  always_comb begin
    ex_tgt  = (state_q == S_IDLE) ? tgt_data : tgt_q;
    ex_diff = q_fb ^ ex_tgt;
`ifdef JK_TOGGLE_EN
    ex_j = ex_diff;
    ex_k = ex_diff;
`else
    ex_j = ex_diff & ex_tgt;
    ex_k = ex_diff & q_fb;
`endif
  end

  // Next-state and registered-output values; j/k default to hold (0) every cycle
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    retry_d = retry_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    ok_d    = ok;
    err_d   = err_mask;
    att_d   = attempts;
    case (state_q)
      S_IDLE: begin
        if (tgt_valid) begin
          tgt_d   = tgt_data;
          retry_d = '0;
          j_d     = ex_j;
          k_d     = ex_k;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (q_fb == tgt_q) begin
          done_d  = 1'b1;
          ok_d    = 1'b1;
          err_d   = '0;
          att_d   = retry_q + AW'(1);
          state_d = S_IDLE;
        end else if (retry_q < AW'(MAX_RETRY)) begin
          retry_d = retry_q + AW'(1);
          j_d     = ex_j;
          k_d     = ex_k;
          state_d = S_DRIVE;
        end else begin
          done_d  = 1'b1;
          ok_d    = 1'b0;
          err_d   = q_fb ^ tgt_q;
          att_d   = retry_q + AW'(1);
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; async reset drops j/k immediately and aborts silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tgt_q    <= '0;
      retry_q  <= '0;
      j        <= '0;
      k        <= '0;
      done     <= 1'b0;
      ok       <= 1'b0;
      err_mask <= '0;
      attempts <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      retry_q  <= retry_d;
      j        <= j_d;
      k        <= k_d;
      done     <= done_d;
      ok       <= ok_d;
      err_mask <= err_d;
      attempts <= att_d;
    end
  end

endmodule

// File: tb/tb_jk_excite_seq.sv
// tb/tb_jk_excite_seq.sv - directed self-checking bench for jk_excite_seq with a negedge JK bank model
module tb_jk_excite_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tgt_valid;
  logic [3:0] tgt_data;
  logic       tgt_ready;
  logic [3:0] q_fb;
  logic [3:0] j, k;
  logic       done, ok;
  logic [3:0] err_mask;
  logic [1:0] attempts;

  logic [3:0] bank_q;
  logic [3:0] bank_init;
  logic       bank_load;
  logic [3:0] stuck0;

  int checks = 0;
  int errors = 0;

  jk_excite_seq #(.WIDTH(4), .MAX_RETRY(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tgt_valid(tgt_valid),
    .tgt_data (tgt_data),
    .tgt_ready(tgt_ready),
    .q_fb     (q_fb),
    .j        (j),
    .k        (k),
    .done     (done),
    .ok       (ok),
    .err_mask (err_mask),
    .attempts (attempts)
  );

  always #5 clk = ~clk;

  // JK register bank on the falling edge, with optional stuck-at-0 bits on readback
  always @(negedge clk) begin
    if (bank_load) bank_q <= bank_init;
    else           bank_q <= (j & ~bank_q) | (~k & bank_q);
  end
  assign q_fb = bank_q & ~stuck0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bank(input logic [3:0] v);
    bank_init = v;
    bank_load = 1'b1;
    cyc();
    bank_load = 1'b0;
  endtask

  task automatic op(input string name, input logic [3:0] tgt,
                    input logic [3:0] exp_j, input logic [3:0] exp_k,
                    input int exp_lat, input logic exp_ok,
                    input logic [3:0] exp_err, input logic [1:0] exp_att);
    int lat;
    tgt_valid = 1'b1;
    tgt_data  = tgt;
    cyc();
    check({name, "_rdy_drive"}, tgt_ready, 1'b0);
    check({name, "_j"}, j, exp_j);
    check({name, "_k"}, k, exp_k);
    tgt_valid = 1'b0;
    tgt_data  = ~tgt;
    lat = 0;
    while (lat < 20) begin
      cyc();
      lat++;
      if (done) break;
      check({name, "_rdy_busy"}, tgt_ready, 1'b0);
    end
    check({name, "_done"}, done, 1'b1);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_ok"}, ok, exp_ok);
    check({name, "_err"}, err_mask, exp_err);
    check({name, "_att"}, attempts, exp_att);
    check({name, "_rdy_done"}, tgt_ready, 1'b1);
    cyc();
    check({name, "_pulse"}, done, 1'b0);
    check({name, "_att_hold"}, attempts, exp_att);
  endtask

  initial begin
    int dcount;
    rst_n     = 1'b0;
    tgt_valid = 1'b0;
    tgt_data  = 4'h0;
    bank_init = 4'h0;
    bank_load = 1'b0;
    stuck0    = 4'h0;
    bank_q    = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", tgt_ready, 1'b1);
    check("rst_j", j, 4'h0);
    check("rst_k", k, 4'h0);
    check("rst_done", done, 1'b0);
    check("rst_ok", ok, 1'b0);
    check("rst_err", err_mask, 4'h0);
    check("rst_att", attempts, 2'd0);
    rst_n = 1'b1;

    // 0000 -> 1010
    load_bank(4'b0000);
`ifdef JK_TOGGLE_EN
    op("t1", 4'b1010, 4'b1010, 4'b1010, 2, 1'b1, 4'b0000, 2'd1);
`else
    op("t1", 4'b1010, 4'b1010, 4'b0000, 2, 1'b1, 4'b0000, 2'd1);
`endif
    check("t1_bank", q_fb, 4'b1010);

    // 1111 -> 0101
    load_bank(4'b1111);
`ifdef JK_TOGGLE_EN
    op("t2", 4'b0101, 4'b1010, 4'b1010, 2, 1'b1, 4'b0000, 2'd1);
`else
    op("t2", 4'b0101, 4'b0000, 4'b1010, 2, 1'b1, 4'b0000, 2'd1);
`endif
    check("t2_bank", q_fb, 4'b0101);

    // bit 0 stuck at 0: all retries used, failure reported
    load_bank(4'b0000);
    stuck0 = 4'b0001;
`ifdef JK_TOGGLE_EN
    op("t3", 4'b0001, 4'b0001, 4'b0001, 6, 1'b0, 4'b0001, 2'd3);
`else
    op("t3", 4'b0001, 4'b0001, 4'b0000, 6, 1'b0, 4'b0001, 2'd3);
`endif
    stuck0 = 4'b0000;

    // target already present
    load_bank(4'b0110);
    op("t6", 4'b0110, 4'b0000, 4'b0000, 2, 1'b1, 4'b0000, 2'd1);

    // tgt_valid held high across two targets
    load_bank(4'b0000);
    tgt_valid = 1'b1;
    tgt_data  = 4'b0011;
    cyc();
    check("t4_rdy0", tgt_ready, 1'b0);
    check("t4_j0", j, 4'b0011);
    tgt_data = 4'b1100;
    cyc();
    check("t4_rdy1", tgt_ready, 1'b0);
    check("t4_jk1", {j, k}, 8'h00);
    cyc();
    check("t4_done0", done, 1'b1);
    check("t4_ok0", ok, 1'b1);
    check("t4_rdy2", tgt_ready, 1'b1);
    cyc();
    check("t4_done_drop", done, 1'b0);
    check("t4_rdy3", tgt_ready, 1'b0);
`ifdef JK_TOGGLE_EN
    check("t4_jk2", {j, k}, 8'hFF);
`else
    check("t4_jk2", {j, k}, 8'hC3);
`endif
    tgt_valid = 1'b0;
    cyc();
    cyc();
    check("t4_done1", done, 1'b1);
    check("t4_ok1", ok, 1'b1);
    check("t4_att1", attempts, 2'd1);
    check("t4_bank", q_fb, 4'b1100);
    cyc();

    // reset pulsed during DRIVE
    load_bank(4'b0000);
    tgt_valid = 1'b1;
    tgt_data  = 4'b1111;
    cyc();
    check("t5_j_drive", j, 4'b1111);
    rst_n     = 1'b0;
    tgt_valid = 1'b0;
    #1;
    check("t5_j_rst", j, 4'h0);
    check("t5_k_rst", k, 4'h0);
    check("t5_rdy_rst", tgt_ready, 1'b1);
    cyc();
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (done) dcount++;
    end
    check("t5_no_done", dcount, 0);
    check("t5_rdy", tgt_ready, 1'b1);
    check("t5_att", attempts, 2'd0);
    check("t5_bank", q_fb, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
